// File: rtl/integral_image_buffer_pkg.sv
// integral_image_buffer_pkg: frame geometry, datapath widths and FSM state
// encodings shared by the integral-image writer and its RAM.
package integral_image_buffer_pkg;

    localparam int II_WIDTH  = 160;
    localparam int II_HEIGHT = 120;
    localparam int II_PIXELS = II_WIDTH * II_HEIGHT;

    localparam int II_ADDR_W = 15;   // covers 0..19199 plus out-of-range probes
    localparam int II_DATA_W = 21;   // external, signed, zero-extended
    localparam int II_SUM_W  = 19;   // stored integral value, max 288000
    localparam int II_ROW_W  = 12;   // running row sum, max 2400
    localparam int II_PIX_W  = 4;

    // One-hot frame-fill states
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_FILL = 3'b010,
        ST_DONE = 3'b100
    } ii_state_e;

endpackage

// File: rtl/integral_image_buffer_ii_ram.sv
// integral_image_buffer_ii_ram: simple dual-port RAM, one write port and one
// registered read port. Read-first on a same-address collision; addresses at
// or beyond DEPTH read back as zero.
module integral_image_buffer_ii_ram
    import integral_image_buffer_pkg::*;
#(
    parameter int DEPTH  = II_PIXELS,
    parameter int ADDR_W = II_ADDR_W,
    parameter int DATA_W = II_SUM_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic              in_range_reg;

    // Write and registered read in one process: the read sees the old word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_addr < DEPTH_A) begin
            rd_data_reg <= mem[rd_addr];
        end
        in_range_reg <= (rd_addr < DEPTH_A);
    end

    assign rd_data = in_range_reg ? rd_data_reg : '0;

endmodule

// File: rtl/integral_image_buffer.sv
// integral_image_buffer: builds the integral image of a raster stream of 4-bit
// pixels on the fly, stores it left-to-right/top-to-bottom in RAM and serves
// classifier reads with a three-cycle latency.
// Optional build macro II_DOUBLE_BUFFER_EN: two RAM banks, readers always see
// the last complete frame while the next one is written to the other bank.
module integral_image_buffer
    import integral_image_buffer_pkg::*;
#(
    parameter int II_WIDTH   = integral_image_buffer_pkg::II_WIDTH,
    parameter int II_HEIGHT  = integral_image_buffer_pkg::II_HEIGHT,
    parameter int RD_LATENCY = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_valid,
    input  logic                        pix_sof,
    input  logic [II_PIX_W-1:0]         pix_in,
    input  logic [II_ADDR_W-1:0]        rd_addr,
    output logic signed [II_DATA_W-1:0] data_out,
    output logic                        frame_ready,
    output logic                        busy,
    output logic                        rd_bank
);

    localparam int XW     = $clog2(II_WIDTH);
    localparam int YW     = $clog2(II_HEIGHT);
    localparam int PIXELS = II_WIDTH * II_HEIGHT;
    localparam logic [XW-1:0] X_LAST = XW'(II_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(II_HEIGHT - 1);
    // address register + RAM register account for two cycles of the latency
    localparam int OUT_STAGES = (RD_LATENCY > 2) ? RD_LATENCY - 2 : 1;

`ifdef II_DOUBLE_BUFFER_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    ii_state_e state_reg, state_next;
    logic      accept;
    logic      sof_hit;

    logic [XW-1:0]        x_reg, eff_x;
    logic [YW-1:0]        y_reg, eff_y;
    logic [II_ADDR_W-1:0] addr_reg, eff_addr;
    logic [II_ROW_W-1:0]  row_sum_reg, row_sum_next;
    logic [II_SUM_W-1:0]  above, ii_next;
    logic                 last_pix;
    logic [II_SUM_W-1:0]  line_buf [II_WIDTH];

    logic                 wr_valid_reg;
    logic [II_ADDR_W-1:0] wr_addr_reg;
    logic [II_SUM_W-1:0]  wr_data_reg;
    logic                 wr_bank;

    logic [II_ADDR_W-1:0] rd_addr_reg;
    logic [II_SUM_W-1:0]  ram_q [NUM_BANKS];
    logic [II_SUM_W-1:0]  ram_sel;
    logic [II_DATA_W-1:0] out_pipe_reg [OUT_STAGES];
    logic                 frame_ready_reg;

    // A start-of-frame pixel restarts the frame from IDLE or mid-FILL
    assign sof_hit = pix_valid && pix_sof && (state_reg != ST_DONE);

    // Frame-fill state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and pixel acceptance
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (sof_hit) begin
                    accept     = 1'b1;
                    state_next = last_pix ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (pix_valid) begin
                    accept     = 1'b1;
                    state_next = last_pix ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Integral value of the pixel on the input this cycle
    always_comb begin
        eff_x        = sof_hit ? '0 : x_reg;
        eff_y        = sof_hit ? '0 : y_reg;
        eff_addr     = sof_hit ? '0 : addr_reg;
        row_sum_next = ((eff_x == '0) ? '0 : row_sum_reg) + II_ROW_W'(pix_in);
        above        = (eff_y == '0) ? '0 : line_buf[eff_x];
        ii_next      = II_SUM_W'(row_sum_next) + above;
        last_pix     = (eff_x == X_LAST) && (eff_y == Y_LAST);
    end

    // Raster position, row sum and write pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg        <= '0;
            y_reg        <= '0;
            addr_reg     <= '0;
            row_sum_reg  <= '0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            wr_valid_reg <= accept;
            if (accept) begin
                addr_reg    <= eff_addr + II_ADDR_W'(1);
                row_sum_reg <= row_sum_next;
                wr_addr_reg <= eff_addr;
                wr_data_reg <= ii_next;
                if (eff_x == X_LAST) begin
                    x_reg <= '0;
                    y_reg <= (eff_y == Y_LAST) ? '0 : eff_y + YW'(1);
                end else begin
                    x_reg <= eff_x + XW'(1);
                    y_reg <= eff_y;
                end
            end
        end
    end

    // Previous-row integral values; row 0 ignores this through the eff_y mux
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[eff_x] <= ii_next;
        end
    end

`ifdef II_DOUBLE_BUFFER_EN
    logic rd_bank_reg;

    // Serve the freshly completed bank from the DONE cycle onwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_reg <= 1'b0;
        end else if (state_reg == ST_DONE) begin
            rd_bank_reg <= ~rd_bank_reg;
        end
    end

    assign wr_bank = ~rd_bank_reg;
    assign ram_sel = ram_q[rd_bank_reg];
    assign rd_bank = rd_bank_reg;
`else
    assign wr_bank = 1'b0;
    assign ram_sel = ram_q[0];
    assign rd_bank = 1'b0;
`endif

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        integral_image_buffer_ii_ram #(
            .DEPTH  (PIXELS),
            .ADDR_W (II_ADDR_W),
            .DATA_W (II_SUM_W)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_valid_reg && (wr_bank == 1'(gi))),
            .wr_addr (wr_addr_reg),
            .wr_data (wr_data_reg),
            .rd_addr (rd_addr_reg),
            .rd_data (ram_q[gi])
        );
    end

    // Read address register, output register(s) and frame-complete pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_reg     <= '0;
            frame_ready_reg <= 1'b0;
            for (int i = 0; i < OUT_STAGES; i++) begin
                out_pipe_reg[i] <= '0;
            end
        end else begin
            rd_addr_reg     <= rd_addr;
            frame_ready_reg <= (state_reg == ST_DONE);
            out_pipe_reg[0] <= II_DATA_W'(ram_sel);
            for (int i = 1; i < OUT_STAGES; i++) begin
                out_pipe_reg[i] <= out_pipe_reg[i-1];
            end
        end
    end

    assign data_out    = out_pipe_reg[OUT_STAGES-1];
    assign frame_ready = frame_ready_reg;
    assign busy        = (state_reg == ST_FILL);

endmodule

// File: tb/tb_integral_image_buffer.sv
// tb_integral_image_buffer: directed frames with hand-computed integral values
// for integral_image_buffer (either build of II_DOUBLE_BUFFER_EN).
module tb_integral_image_buffer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               pix_valid = 1'b0;
    logic               pix_sof = 1'b0;
    logic [3:0]         pix_in = '0;
    logic [14:0]        rd_addr = '0;
    logic signed [20:0] data_out;
    logic               frame_ready;
    logic               busy;
    logic               rd_bank;

    int   checks = 0;
    int   errors = 0;
    int   fr_count = 0;
    int   fr_before;
    int   cyc;
    logic exp_bank = 1'b0;

    integral_image_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_sof     (pix_sof),
        .pix_in      (pix_in),
        .rd_addr     (rd_addr),
        .data_out    (data_out),
        .frame_ready (frame_ready),
        .busy        (busy),
        .rd_bank     (rd_bank)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_ready) fr_count++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic sof, input logic [3:0] v);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_in    = v;
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic read_check(input int addr, input int exp, input string tag);
        rd_addr = 15'(addr);
        tick();
        tick();
        tick();
        check_val(tag, data_out, exp);
    endtask

    // Called in the cycle right after the last pixel was accepted
    task automatic frame_end_check(input string tag);
        check_val({tag, "_fr_k1"}, frame_ready, 1'b0);
        tick();
        check_val({tag, "_fr_k2"}, frame_ready, 1'b1);
        check_val({tag, "_busy_k2"}, busy, 1'b0);
`ifdef II_DOUBLE_BUFFER_EN
        exp_bank = ~exp_bank;
`endif
        check_val({tag, "_rd_bank"}, rd_bank, exp_bank);
        tick();
        check_val({tag, "_fr_k3"}, frame_ready, 1'b0);
    endtask

    // Integral of pixel value (x % 16) over [0..x]x[0..y]
    function automatic int ii_ref(input int a);
        int x, y, s;
        x = a % 160;
        y = a / 160;
        s = 0;
        for (int i = 0; i <= x; i++) s += i % 16;
        return s * (y + 1);
    endfunction

    initial begin
        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check_val("rst_data_out", data_out, 0);
        check_val("rst_frame_ready", frame_ready, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_rd_bank", rd_bank, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // non-SOF pixels in IDLE are ignored
        pix_valid = 1'b1;
        pix_sof   = 1'b0;
        pix_in    = 4'd7;
        tick();
        tick();
        pix_valid = 1'b0;
        check_val("idle_ignore_busy", busy, 1'b0);

        // frame 1: all pixels 15
        fr_before = fr_count;
        for (int p = 0; p < 19200; p++) begin
            send_pix(p == 0, 4'd15);
            if (p == 1000) check_val("f1_busy_mid", busy, 1'b1);
        end
        frame_end_check("f1");
        check_val("f1_fr_count", fr_count - fr_before, 1);
        read_check(0, 15, "f1_ii_0");
        read_check(159, 2400, "f1_ii_159");
        read_check(160, 30, "f1_ii_160");
        read_check(20000, 0, "f1_oob_20000");
        read_check(32767, 0, "f1_oob_32767");
        read_check(19199, 288000, "f1_ii_19199");

        // back-to-back reads: address 0..7, data three cycles later
        for (int t = 0; t < 10; t++) begin
            rd_addr = (t < 8) ? 15'(t) : 15'd0;
            tick();
            if (t < 2) check_val("lat_hold", data_out, 288000);
            else       check_val("lat_stream", data_out, 15 * (t - 1));
        end

        // aborted frame: SOF again at pixel 500, then a full all-1 frame
        fr_before = fr_count;
        for (int p = 0; p < 500; p++) send_pix(p == 0, 4'd1);
        for (int p = 0; p < 19200; p++) begin
            send_pix(p == 0, 4'd1);
            if (p == 1000) begin
                read_check(19199, 288000, "b_fill_old_frame");
                check_val("b_fill_rd_bank", rd_bank, exp_bank);
                check_val("b_fill_busy", busy, 1'b1);
            end
        end
        frame_end_check("b");
        check_val("b_fr_count", fr_count - fr_before, 1);
        read_check(19199, 19200, "b_ii_19199");
        read_check(0, 1, "b_ii_0");
        read_check(500, 84, "b_ii_500");

        // asynchronous reset in the middle of a frame
        rd_addr = 15'd19199;
        for (int p = 0; p < 50; p++) send_pix(p == 0, 4'd2);
        tick();
        tick();
        tick();
        check_val("pre_rst_busy", busy, 1'b1);
        check_val("pre_rst_data_out", data_out, 19200);
        #3 rst = 1'b1;
        #1;
        check_val("mid_rst_data_out", data_out, 0);
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_frame_ready", frame_ready, 1'b0);
        check_val("mid_rst_rd_bank", rd_bank, 1'b0);
        exp_bank = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // frame of pixel (x % 16) with a pix_valid gap every third cycle
        fr_before = fr_count;
        cyc = 0;
        for (int p = 0; p < 19200; p++) begin
            if (cyc % 3 == 2) begin
                tick();
                cyc++;
            end
            send_pix(p == 0, 4'((p % 160) % 16));
            cyc++;
            if (p == 5000) check_val("g_busy_mid", busy, 1'b1);
        end
        frame_end_check("g");
        check_val("g_fr_count", fr_count - fr_before, 1);
        read_check(0, 0, "g_ii_0");
        read_check(17, 121, "g_ii_17");
        read_check(165, 30, "g_ii_165");
        read_check(19199, 144000, "g_ii_19199");
        for (int i = 0; i < 20; i++) begin
            int a;
            a = int'($urandom_range(0, 19199));
            read_check(a, ii_ref(a), $sformatf("g_rand_%0d", a));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
